// File: rtl/fc_out_requant.sv
`default_nettype none
// ============================================================================
// Module      : fc_out_requant
// Description : Output stage for the fully-connected core. Each 57-bit signed
//               dot product is rounded (half-up), arithmetically shifted right,
//               optionally ReLU-clamped and saturated to signed 8 bits, then
//               queued in a small FIFO that feeds a valid/ready stream.
//               The FC core cannot be stalled, so a result arriving at a full
//               FIFO is discarded and a sticky overflow flag is raised.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               i_valid, i_acc    - result strobe and 57-bit signed result
//               cfg_shift         - right-shift amount (clamped to 56)
//               cfg_relu          - 1 = negative results become 0
//               out_valid/out_data/out_ready - output stream (FIFO head)
//               overflow          - sticky drop indicator
//               sat_count         - saturating count of clamped results
// Revision    : 1.0 - initial release
// ============================================================================
module fc_out_requant #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [56:0]      i_acc,
    input  logic [5:0]       cfg_shift,
    input  logic             cfg_relu,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] sat_count
);

    localparam int                   c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0]     c_FULL    = (c_PTR_W + 1)'(DEPTH);
    localparam logic [5:0]           c_SH_MAX  = 6'd56;
    localparam logic signed [57:0]   c_SAT_HI  = 58'sd127;
    localparam logic signed [57:0]   c_SAT_LO  = -58'sd128;

    // ------------------------------------------------------------------
    // Stage 1: clamp shift, add rounding constant, capture config with data
    // ------------------------------------------------------------------
    logic [5:0]  w_sh;
    logic [57:0] w_round;
    logic [57:0] w_sum;

    assign w_sh    = (cfg_shift > c_SH_MAX) ? c_SH_MAX : cfg_shift;
    // Half of one output LSB, so the later floor shift rounds half-up.
    assign w_round = (w_sh == 6'd0) ? 58'd0 : (58'd1 << (w_sh - 6'd1));
    // One extra bit keeps the rounding add from wrapping for large inputs.
    assign w_sum   = {i_acc[56], i_acc} + w_round;

    logic        r_s1_valid;
    logic [57:0] r_s1_sum;
    logic [5:0]  r_s1_sh;
    logic        r_s1_relu;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_sh    <= '0;
            r_s1_relu  <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_sum  <= w_sum;
                r_s1_sh   <= w_sh;
                r_s1_relu <= cfg_relu;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift, ReLU, saturate (combinational into the FIFO write)
    // ------------------------------------------------------------------
    logic signed [57:0] w_shifted;
    logic signed [57:0] w_t;
    logic [7:0]         w_q;
    logic               w_sat;

    assign w_shifted = $signed(r_s1_sum) >>> r_s1_sh;
    assign w_t       = (r_s1_relu && w_shifted[57]) ? '0 : w_shifted;

    always_comb begin
        w_q   = w_t[7:0];
        w_sat = 1'b0;
        if (w_t > c_SAT_HI) begin
            w_q   = 8'h7F;
            w_sat = 1'b1;
        end else if (w_t < c_SAT_LO) begin
            w_q   = 8'h80;
            w_sat = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: circular buffer with explicit occupancy count
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_sat_count;

    logic w_full;
    logic w_rd;
    logic w_wr;

    assign w_full = (r_count == c_FULL);
    assign w_rd   = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_wr   = r_s1_valid && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_sat_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= w_q;
                r_wptr        <= r_wptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (r_s1_valid && !w_wr) begin
                r_overflow <= 1'b1;
            end
            // Every processed result that clamps is counted, dropped or not.
            if (r_s1_valid && w_sat && (r_sat_count != {CNT_W{1'b1}})) begin
                r_sat_count <= r_sat_count + CNT_W'(1);
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rptr];
    assign overflow  = r_overflow;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_fc_out_requant.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_out_requant
// Description : Self-checking bench for fc_out_requant. Directed scenarios
//               plus a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_out_requant;

    localparam int c_DEPTH = 4;
    localparam int c_CNT_W = 16;

    logic               clk;
    logic               reset;
    logic               i_valid;
    logic [56:0]        i_acc;
    logic [5:0]         cfg_shift;
    logic               cfg_relu;
    logic               out_valid;
    logic [7:0]         out_data;
    logic               out_ready;
    logic               overflow;
    logic [c_CNT_W-1:0] sat_count;

    int n_cmp;
    int n_err;

    fc_out_requant #(
        .DEPTH (c_DEPTH),
        .CNT_W (c_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_acc     (i_acc),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: round half-up, floor shift, ReLU, clamp. Bit 8 = saturated.
    function automatic logic [8:0] ref_q(input logic [56:0] acc, input logic [5:0] sh_in,
                                         input logic relu);
        longint a;
        longint t;
        int     sh;
        logic [7:0] lo;
        a  = longint'($signed(acc));
        sh = (sh_in > 6'd56) ? 56 : int'(sh_in);
        if (sh > 0) a = a + (longint'(1) << (sh - 1));
        t = a >>> sh;
        if (relu && t < 0) t = 0;
        if (t > 127)  return {1'b1, 8'h7F};
        if (t < -128) return {1'b1, 8'h80};
        lo = t[7:0];
        return {1'b0, lo};
    endfunction

    // Stimulus helpers (no checking inside)
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sends one word with out_ready=1; returns out_valid one cycle later,
    // and out_valid/out_data two cycles later. Leaves the word consumed.
    task automatic run_one(input logic [56:0] acc, input logic [5:0] sh, input logic relu,
                           output logic v_early, output logic v, output logic [7:0] d);
        out_ready = 1'b1;
        i_valid   = 1'b1;
        i_acc     = acc;
        cfg_shift = sh;
        cfg_relu  = relu;
        @(negedge clk);
        i_valid   = 1'b0;
        cfg_shift = 6'd63;
        cfg_relu  = 1'b1;
        v_early   = out_valid;
        @(negedge clk);
        v = out_valid;
        d = out_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", out_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if (sat_count !== '0) begin n_err++; $display("FAIL reset_sat got %0d want 0", sat_count); end
    endtask

    task automatic test_basic();
        logic ve, v; logic [7:0] d;
        run_one(57'd1000, 6'd3, 1'b0, ve, v, d);
        n_cmp++; if (ve !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %b want 0", ve); end
        n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", v); end
        n_cmp++; if (d !== 8'h7D) begin n_err++; $display("FAIL basic_data got %h want 7d", d); end
        n_cmp++; if (sat_count !== 16'd0) begin n_err++; $display("FAIL basic_sat got %0d want 0", sat_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic ve, v; logic [7:0] d;
        run_one(57'd1023, 6'd3, 1'b0, ve, v, d);
        n_cmp++; if (d !== 8'h7F) begin n_err++; $display("FAIL sat_pos_data got %h want 7f", d); end
        n_cmp++; if (sat_count !== 16'd1) begin n_err++; $display("FAIL sat_pos_cnt got %0d want 1", sat_count); end
        run_one(-57'sd2000, 6'd0, 1'b0, ve, v, d);
        n_cmp++; if (d !== 8'h80) begin n_err++; $display("FAIL sat_neg_data got %h want 80", d); end
        n_cmp++; if (sat_count !== 16'd2) begin n_err++; $display("FAIL sat_neg_cnt got %0d want 2", sat_count); end
        // Shift above 56 is clamped: 2^56-1 rounds to 1 at shift 56
        run_one(57'h0FF_FFFF_FFFF_FFFF, 6'd63, 1'b0, ve, v, d);
        n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL shift_clamp got %h want 01", d); end
    endtask

    task automatic test_relu();
        logic ve, v; logic [7:0] d;
        run_one(-57'sd1000, 6'd3, 1'b0, ve, v, d);
        n_cmp++; if (d !== 8'h83) begin n_err++; $display("FAIL neg_round got %h want 83", d); end
        run_one(-57'sd1000, 6'd3, 1'b1, ve, v, d);
        n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL relu_data got %h want 00", d); end
        n_cmp++; if (sat_count !== 16'd2) begin n_err++; $display("FAIL relu_sat got %0d want 2", sat_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        cfg_shift = 6'd0;
        cfg_relu  = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            i_valid = 1'b1;
            i_acc   = 57'(k);
            @(negedge clk);
        end
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
                n_err++; $display("FAIL ovf_drain[%0d] got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, k);
            end
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %b want 0", out_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int popped;
        do_reset();
        popped    = 0;
        out_ready = 1'b0;
        cfg_shift = 6'd0;
        cfg_relu  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_acc = 57'(10 + k); exp_q.push_back(8'(10 + k));
            @(negedge clk);
        end
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'(20 + k));
        // First stream word lands in S1 while full; the next edge writes and pops together.
        for (int c = 0; c < 20; c++) begin
            i_valid   = (c < 8);
            i_acc     = 57'(20 + c);
            out_ready = (c >= 1);
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra got %0d want none", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        n_err++; $display("FAIL b2b_data got %0d want %0d", out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                popped++;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        n_cmp++; if (popped != 12) begin n_err++; $display("FAIL b2b_count got %0d want 12", popped); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %b want 0", overflow); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic ve, v; logic [7:0] d;
        do_reset();
        out_ready = 1'b0;
        cfg_shift = 6'd0;
        cfg_relu  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1; i_acc = 57'(40 + k);
            @(negedge clk);
        end
        // 3 words in FIFO, 1 in S1; input during reset must be ignored
        reset = 1'b1; i_valid = 1'b1; i_acc = 57'd99;
        @(negedge clk);
        reset = 1'b0; i_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h want 00", out_data); end
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale got %b want 0", out_valid); end
        run_one(57'd77, 6'd0, 1'b0, ve, v, d);
        n_cmp++; if (ve !== 1'b0 || v !== 1'b1 || d !== 8'd77) begin
            n_err++; $display("FAIL rmid_new got ve=%b v=%b d=%0d want ve=0 v=1 d=77", ve, v, d);
        end
    endtask

    task automatic test_random();
        logic [7:0] m_q[$];
        logic       m_s1v;
        logic [8:0] m_s1;
        logic       m_ovf;
        int         m_sat;
        logic       rd;
        int         errs_before;
        do_reset();
        m_s1v = 1'b0; m_s1 = '0; m_ovf = 1'b0; m_sat = 0;
        errs_before = n_err;
        for (int c = 0; c < 400; c++) begin
            // Compare DUT against the model (stop printing after a few errors)
            n_cmp++;
            if (out_valid !== (m_q.size() > 0) ||
                (m_q.size() > 0 && out_data !== m_q[0]) ||
                overflow !== m_ovf || sat_count !== 16'(m_sat)) begin
                n_err++;
                if (n_err - errs_before < 5)
                    $display("FAIL rand[%0d] got v=%b d=%h ovf=%b sat=%0d want v=%b d=%h ovf=%b sat=%0d",
                             c, out_valid, out_data, overflow, sat_count, m_q.size() > 0,
                             (m_q.size() > 0) ? m_q[0] : 8'h00, m_ovf, m_sat);
            end
            // New stimulus for the coming edge
            i_valid   = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            cfg_relu  = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                i_acc     = {$urandom, $urandom} >> 7;
                cfg_shift = 6'($urandom_range(0, 63));
            end else begin
                i_acc     = 57'(longint'($urandom_range(0, 4000)) - 2000);
                cfg_shift = 6'($urandom_range(0, 5));
            end
            // Model the coming edge: pop, then process the S1 word, then load S1
            rd = (m_q.size() > 0) && out_ready;
            if (rd) void'(m_q.pop_front());
            if (m_s1v) begin
                if (m_s1[8]) m_sat++;
                if (m_q.size() < c_DEPTH) m_q.push_back(m_s1[7:0]);
                else m_ovf = 1'b1;
            end
            m_s1v = i_valid;
            if (i_valid) m_s1 = ref_q(i_acc, cfg_shift, cfg_relu);
            @(negedge clk);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        i_valid   = 1'b0;
        i_acc     = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
